// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// multicycle_alu: valid/ready ALU with optional iterative MUL/DIVU/REMU
// (build with `define ALU_MULDIV_EN to enable).      Revision: 1.0
// ============================================================================
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       alu_src,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             zero,
  output logic             branch_taken
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] F_ADD    = 4'b0000;
  localparam logic [3:0] F_ADDI   = 4'b0001;
  localparam logic [3:0] F_LOAD   = 4'b0010;
  localparam logic [3:0] F_STORE  = 4'b0011;
  localparam logic [3:0] F_LUI    = 4'b0100;
  localparam logic [3:0] F_JUMP   = 4'b0101;
  localparam logic [3:0] F_OR     = 4'b0110;
  localparam logic [3:0] F_AND    = 4'b0111;
  localparam logic [3:0] F_BRANCH = 4'b1000;
  localparam logic [3:0] F_SUB    = 4'b1001;
  localparam logic [3:0] F_XOR    = 4'b1101;
  localparam logic [3:0] F_SLL    = 4'b1110;
  localparam logic [3:0] F_SRL    = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] bs;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_out;
  logic             sc_c;
  logic             sc_br;
  logic             accept;
  logic             sc_accept;

  always_comb begin
    case (alu_src)
      2'b01, 2'b10: bs = imm;
      default:      bs = B;
    endcase
  end

  assign sum    = {1'b0, A} + {1'b0, bs};
  assign diff   = {1'b0, A} - {1'b0, bs};
  assign shamt  = bs[SHW-1:0];
  assign sc_br  = ((func == F_BRANCH) && (A == bs)) || (func == F_JUMP);
  assign accept = in_valid && in_ready;

  // Codes without a case item (MUL/DIVU/REMU when the iterative unit is absent) yield 0.
  always_comb begin
    sc_out = '0;
    sc_c   = 1'b0;
    case (func)
      F_ADD, F_ADDI, F_LOAD, F_STORE: begin
        sc_out = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
      end
      F_LUI, F_JUMP:     sc_out = bs;
      F_OR:              sc_out = A | bs;
      F_AND:             sc_out = A & bs;
      F_BRANCH, F_SUB: begin
        sc_out = diff[WIDTH-1:0];
        sc_c   = diff[WIDTH];
      end
      F_XOR:             sc_out = A ^ bs;
      F_SLL:             sc_out = A << shamt;
      F_SRL:             sc_out = A >> shamt;
      default:           sc_out = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [3:0] F_MUL  = 4'b1010;
  localparam logic [3:0] F_DIVU = 4'b1011;
  localparam logic [3:0] F_REMU = 4'b1100;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  logic             is_md;
  logic             md_accept;
  logic             md_done;
  logic [SHW:0]     cnt;
  logic [3:0]       func_q;
  logic [WIDTH-1:0] acc_q, quo_q, opb_q;
  logic [WIDTH-1:0] acc_n, quo_n, opb_n;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] md_result;

  assign is_md     = (func == F_MUL) || (func == F_DIVU) || (func == F_REMU);
  assign md_accept = accept && is_md;
  assign sc_accept = accept && !is_md;
  assign md_done   = (state == S_BUSY) && (cnt == CNT_LAST);

  // MUL: acc accumulates, quo holds the multiplier, opb the shifting multiplicand.
  // DIVU/REMU: acc is the partial remainder, quo shifts dividend out and quotient in.
  // A zero divisor always "fits", giving an all-ones quotient and remainder == A.
  assign rem_sh = {acc_q, quo_q[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, opb_q};

  always_comb begin
    acc_n = acc_q;
    quo_n = quo_q;
    opb_n = opb_q;
    if (func_q == F_MUL) begin
      acc_n = acc_q + (quo_q[0] ? opb_q : '0);
      opb_n = opb_q << 1;
      quo_n = quo_q >> 1;
    end else begin
      acc_n = ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], ge};
    end
  end

  assign md_result = (func_q == F_DIVU) ? quo_n : acc_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (md_accept) begin
      cnt    <= CNT_INIT;
      func_q <= func;
      acc_q  <= '0;
      quo_q  <= (func == F_MUL) ? bs : A;
      opb_q  <= (func == F_MUL) ? A : bs;
    end else if (state == S_BUSY) begin
      cnt   <= cnt - 1'b1;
      acc_q <= acc_n;
      quo_q <= quo_n;
      opb_q <= opb_n;
    end
  end
`else
  assign sc_accept = accept;
`endif

  assign in_ready = rst_n && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      out          <= '0;
      c_out        <= 1'b0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sc_accept) begin
            state        <= S_DONE;
            out          <= sc_out;
            c_out        <= sc_c;
            zero         <= (sc_out == '0);
            branch_taken <= sc_br;
            out_valid    <= 1'b1;
          end
`ifdef ALU_MULDIV_EN
          if (md_accept) begin
            state <= S_BUSY;
          end
`endif
        end
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          if (md_done) begin
            state        <= S_DONE;
            out          <= md_result;
            c_out        <= 1'b0;
            zero         <= (md_result == '0);
            branch_taken <= 1'b0;
            out_valid    <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// tb_multicycle_alu: directed self-checking bench for multicycle_alu.
// Revision: 1.0
// ============================================================================
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B, imm;
  logic [1:0]  alu_src;
  logic [3:0]  func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        c_out, zero, branch_taken;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ALU_MULDIV_EN
  localparam int MD_LAT = 33;
  localparam bit MD_ON  = 1'b1;
`else
  localparam int MD_LAT = 1;
  localparam bit MD_ON  = 1'b0;
`endif

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .imm(imm), .alu_src(alu_src), .func(func),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .c_out(c_out), .zero(zero), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge with inputs scrambled.
  task automatic launch(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [1:0] src);
    int guard = 0;
    A = a; B = b; imm = im; alu_src = src; func = f; in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; imm = ~im; func = ~f;
  endtask

  task automatic wait_result(output int lat, output bit leak);
    lat = 1; leak = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) leak = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic [1:0] src,
                        input logic [31:0] eo, input logic ec, input logic ebr, input int elat);
    int lat; bit leak;
    launch(f, a, b, im, src);
    wait_result(lat, leak);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_out"}, out, eo);
    check({tag, "_cout"}, 32'(c_out), 32'(ec));
    check({tag, "_zero"}, 32'(zero), 32'(eo == 32'd0));
    check({tag, "_br"}, 32'(branch_taken), 32'(ebr));
    check({tag, "_busy_rdy"}, 32'(leak), 32'd0);
    pop();
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; imm = '0; alu_src = 2'b00; func = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_flags", {29'd0, c_out, zero, branch_taken}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single-cycle group
    run_op("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 2'b00, 32'd0, 1'b1, 1'b0, 1);
    run_op("addi", 4'b0001, 32'd10, 32'd99, 32'd5, 2'b01, 32'd15, 1'b0, 1'b0, 1);
    run_op("load_b11", 4'b0010, 32'd10, 32'd7, 32'd100, 2'b11, 32'd17, 1'b0, 1'b0, 1);
    run_op("lui", 4'b0100, 32'd1, 32'd0, 32'hABCD0000, 2'b10, 32'hABCD0000, 1'b0, 1'b0, 1);
    run_op("jump", 4'b0101, 32'd0, 32'h40, 32'd0, 2'b00, 32'h40, 1'b0, 1'b1, 1);
    run_op("or", 4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 2'b00, 32'hF0F0_0F0F, 1'b0, 1'b0, 1);
    run_op("and", 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 2'b00, 32'h0F00_0F00, 1'b0, 1'b0, 1);
    run_op("xor", 4'b1101, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 2'b00, 32'h5555_5555, 1'b0, 1'b0, 1);
    run_op("srl", 4'b1111, 32'h8000_0000, 32'd31, 32'd0, 2'b00, 32'd1, 1'b0, 1'b0, 1);
    run_op("branch_eq", 4'b1000, 32'd5, 32'd9, 32'd5, 2'b10, 32'd0, 1'b0, 1'b1, 1);
    run_op("branch_ne", 4'b1000, 32'd5, 32'd4, 32'd0, 2'b00, 32'd1, 1'b0, 1'b0, 1);
    run_op("sub_borrow", 4'b1001, 32'd3, 32'd5, 32'd0, 2'b00, 32'hFFFFFFFE, 1'b1, 1'b0, 1);

    // Iterative group
    run_op("mul", 4'b1010, 32'd7, 32'd6, 32'd0, 2'b00, MD_ON ? 32'd42 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("mul_big", 4'b1010, 32'h0001_0003, 32'h0001_0000, 32'd0, 2'b00,
           MD_ON ? 32'h0003_0000 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("divu", 4'b1011, 32'd100, 32'd7, 32'd0, 2'b00, MD_ON ? 32'd14 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("remu", 4'b1100, 32'd100, 32'd7, 32'd0, 2'b00, MD_ON ? 32'd2 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("divu_z", 4'b1011, 32'd5, 32'd0, 32'd0, 2'b00, MD_ON ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("remu_z", 4'b1100, 32'd5, 32'd0, 32'd0, 2'b00, MD_ON ? 32'd5 : 32'd0, 1'b0, 1'b0, MD_LAT);

    // Back-pressure: result held while out_ready stays low
    begin
      int lat; bit leak;
      launch(4'b1110, 32'd1, 32'h24, 32'd0, 2'b00);
      wait_result(lat, leak);
      check("sll_lat", 32'(lat), 32'd1);
      for (int i = 0; i < 5; i++) begin
        check("hold_out", out, 32'h10);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_flags", {29'd0, c_out, zero, branch_taken}, 32'd0);
        check("hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
      pop();
    end

    // Reset in the middle of an operation
    launch(4'b1010, 32'd7, 32'd6, 32'd0, 2'b00);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("midrst_valid2", 32'(out_valid), 32'd0);
    run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd0, 2'b00, 32'd5, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
